matrix_spi_tx: RTL

MATRIX_SPI_TX -- requirements
Module: matrix_spi_tx

---
 rtl/snake_pkg.sv | 13 +
 rtl/edge_detect.sv | 23 ++
 rtl/matrix_spi_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the matrix display serial transmitter.
package snake_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StFinish
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector for a slow clk-domain signal.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sclk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= sig;
    end
  end

  assign rise = sig & ~sclk_q;
  assign fall = ~sig & sclk_q;

endmodule

// File: rtl/matrix_spi_tx.sv
// MSB-first serial frame transmitter for the LED matrix driver, paced by an
// externally divided serial clock.
module matrix_spi_tx
  import snake_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             sdo,
  output logic             cs_n,
  output logic             sclk_out
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [WIDTH-1:0]  shift_q;
  logic              rise;
  logic              fall;

  edge_detect u_edge_detect (
    .clk  (clk),
    .reset(reset),
    .sig  (sclk_in),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sdo       <= 1'b0;
      cs_n      <= 1'b1;
      sclk_out  <= 1'b0;
    end else begin
      done     <= 1'b0;
      sclk_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q   <= data_in;
            sdo       <= data_in[WIDTH-1];
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (fall) begin
            state_q <= StShift;
          end
        end
        StShift: begin
          sclk_out <= sclk_in;
          if (rise) begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
          // Data changes only on falls, so it is settled before each sclk_out rise.
          if (fall) begin
            if (bit_cnt_q == CntW'(WIDTH)) begin
              cs_n    <= 1'b1;
              sdo     <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StFinish;
            end else begin
              shift_q <= {shift_q[WIDTH-2:0], 1'b0};
              sdo     <= shift_q[WIDTH-2];
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
